// File: rtl/ysyx_22050854_div_unit_pkg.sv
// Shared definitions for the EX-stage divide unit: MULctr div/rem codes, width, FSM states.
package ysyx_22050854_defs;

    localparam int XLEN = 64;

    localparam logic [3:0] MUL_DIV   = 4'b0100;
    localparam logic [3:0] MUL_DIVU  = 4'b0101;
    localparam logic [3:0] MUL_REM   = 4'b0110;
    localparam logic [3:0] MUL_REMU  = 4'b0111;
    localparam logic [3:0] MUL_DIVW  = 4'b1100;
    localparam logic [3:0] MUL_DIVUW = 4'b1101;
    localparam logic [3:0] MUL_REMW  = 4'b1110;
    localparam logic [3:0] MUL_REMUW = 4'b1111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // bit2 set selects exactly the eight div/rem codes; bit3 word, bit1 rem, bit0 unsigned
    function automatic logic is_divrem(input logic [3:0] c);
        return c[2];
    endfunction

endpackage

// File: rtl/ysyx_22050854_div_unit.sv
// Radix-2 restoring divide/remainder engine for RV64M; one quotient bit per cycle,
// divide-by-zero and signed overflow resolved at accept.
module ysyx_22050854_div_unit
    import ysyx_22050854_defs::*;
#(
    parameter int XLEN = ysyx_22050854_defs::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mulctr,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int H  = XLEN / 2;
    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext_w(input logic [H-1:0] v);
        return {{H{v[H-1]}}, v};
    endfunction

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] dvd, dvs, rem;
    logic            is_w, is_rem, neg_q, neg_r;

    logic            op_w, op_u, op_r, a_neg, b_neg, ovf;
    logic [XLEN-1:0] a, b, a_abs, b_abs, min_v, spec_raw, spec_res;

    assign op_w = mulctr[3];
    assign op_r = mulctr[1];
    assign op_u = mulctr[0];

    always_comb begin
        a = src1;
        b = src2;
        if (op_w) begin
            a = op_u ? {{H{1'b0}}, src1[H-1:0]} : sext_w(src1[H-1:0]);
            b = op_u ? {{H{1'b0}}, src2[H-1:0]} : sext_w(src2[H-1:0]);
        end
        min_v    = op_w ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        a_neg    = !op_u && a[XLEN-1];
        b_neg    = !op_u && b[XLEN-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        ovf      = !op_u && (a == min_v) && (b == '1);
        spec_raw = (b == '0) ? (op_r ? a : '1) : (op_r ? '0 : a);
        spec_res = op_w ? sext_w(spec_raw[H-1:0]) : spec_raw;
    end

    // Word ops park the dividend in the upper half so the msb shifts out first;
    // quotient bits collect in the low end of dvd.
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_nx, dvd_nx, raw, fix, fin_res;

    always_comb begin
        rem_sh  = {rem, dvd[XLEN-1]};
        ge      = rem_sh >= {1'b0, dvs};
        rem_nx  = ge ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];
        dvd_nx  = {dvd[XLEN-2:0], ge};
        raw     = is_rem ? rem_nx : (is_w ? {{H{1'b0}}, dvd_nx[H-1:0]} : dvd_nx);
        fix     = (is_rem ? neg_r : neg_q) ? -raw : raw;
        fin_res = is_w ? sext_w(fix[H-1:0]) : fix;
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            is_w   <= 1'b0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid && is_divrem(mulctr)) begin
                    if (b == '0 || ovf) begin
                        result <= spec_res;
                        state  <= S_DONE;
                    end else begin
                        dvd    <= op_w ? {a_abs[H-1:0], {H{1'b0}}} : a_abs;
                        dvs    <= b_abs;
                        rem    <= '0;
                        is_w   <= op_w;
                        is_rem <= op_r;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        count  <= op_w ? CW'(H - 1) : CW'(XLEN - 1);
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    dvd   <= dvd_nx;
                    rem   <= rem_nx;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result <= fin_res;
                        state  <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_div_unit.sv
// Scoreboard bench for the divide unit: directed corner cases, flush/reset, random ops vs a behavioural model.
module tb_ysyx_22050854_div_unit;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]  mulctr = '0;
    logic [63:0] src1 = '0, src2 = '0;
    logic        in_ready, out_valid;
    logic [63:0] result;

    ysyx_22050854_div_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mulctr(mulctr), .src1(src1), .src2(src2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] res; int lat; } exp_t;
    exp_t sb_q[$];
    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic ref_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
        logic w, u, r;
        logic [63:0] ua, ub;
        logic signed [63:0] sa, sb;
        w = c[3]; r = c[1]; u = c[0];
        ua = a; ub = b;
        if (w) begin
            ua = u ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            ub = u ? {32'b0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end
        sa = ua; sb = ub;
        lat = 1;
        if (ub == 0) res = r ? ua : '1;
        else if (!u && ub == '1 && ua == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
            res = r ? 64'd0 : ua;
        else begin
            lat = w ? 33 : 65;
            if (u) res = r ? ua % ub : ua / ub;
            else   res = r ? $unsigned(sa % sb) : $unsigned(sa / sb);
        end
        if (w) res = {{32{res[31]}}, res[31:0]};
    endtask

    // Called at posedge+1; drives one op and retires the head of the scoreboard.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        exp_t e;
        int lat;
        mulctr = c; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom}; mulctr = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check({tag, "/lat"}, 64'(lat), 64'(e.lat));
        check({tag, "/res"}, result, e.res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "/held"}, {result, out_valid, in_ready}, {e.res, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/release"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    task automatic dir_op(input string tag, input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] res, input int lat, input int hold);
        sb_q.push_back('{res: res, lat: lat});
        run_op(tag, c, a, b, hold);
    endtask

    task automatic rnd_op(input string tag, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        int l;
        ref_op(c, a, b, r, l);
        sb_q.push_back('{res: r, lat: l});
        run_op(tag, c, a, b, 0);
    endtask

    initial begin
        logic [3:0]  codes [8] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        logic [63:0] ra, rb;
        logic        seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset", {result, out_valid, in_ready}, {64'd0, 1'b0, 1'b1});
        rst_n = 1'b1;
        @(posedge clk); #1;

        dir_op("divu",   4'b0101, 64'd100, 64'd7, 64'd14, 65, 0);
        dir_op("remu",   4'b0111, 64'd100, 64'd7, 64'd2, 65, 0);
        dir_op("rem_neg", 4'b0110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        dir_op("div_neg", 4'b0100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        dir_op("div_z",  4'b0100, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        dir_op("remu_z", 4'b0111, 64'd5, 64'd0, 64'd5, 1, 0);
        dir_op("div_ovf", 4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
        dir_op("rem_ovf", 4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
        dir_op("divw_ovf", 4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
        dir_op("divuw",  4'b1101, 64'hDEAD_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 0);
        dir_op("remuw",  4'b1111, 64'hFFFF_FFFF, 64'h10, 64'h0F, 33, 0);
        dir_op("divuw_sx", 4'b1101, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        dir_op("remw_neg", 4'b1110, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        dir_op("hold",   4'b0101, 64'd100, 64'd7, 64'd14, 65, 5);

        // Codes outside the div/rem set must not start the engine.
        mulctr = 4'b0000; src1 = 64'd9; src2 = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("illegal", {62'd0, out_valid, in_ready}, 64'b01);

        mulctr = 4'b0101; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush", {62'd0, out_valid, in_ready}, 64'b01);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush/no_out", {63'd0, seen}, 64'd0);

        // Previous result is 14; asynchronous reset must clear it mid-CALC.
        mulctr = 4'b0101; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {result, out_valid, in_ready}, {64'd0, 1'b0, 1'b1});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        dir_op("post_rst", 4'b0100, 64'd1000, -64'sd3, -64'sd333, 65, 0);

        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = {$urandom, $urandom};
                1: rb = 64'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? -64'sd1 : 64'sd1);
                2: rb = '0;
                3: begin rb = '1; ra = ($urandom_range(0, 1) == 1) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000; end
                default: rb = {32'd0, $urandom};
            endcase
            rnd_op("rand", codes[$urandom_range(0, 7)], ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
